result_skid_stage: RTL and testbench
====================================

// Module: result_skid_stage
// PURPOSE
//  Per-lane output stage placed directly downstream of the shared-resource stage. Registers
//  each result and holds up to DEPTH results in a small in-order skid FIFO. Propagates
//  valid/stall/flush between the shared-resource stage and the consuming pipeline. Keeps
//  saturating throughput and stall counters for the lane.
// PARAMETERS
//  DATA_WIDTH  32  width of result data
//  DEPTH       2   skid FIFO entries; power of two, >=2
//  CNT_WIDTH   16  width of accept_count / stall_count
// PORTS
//  clk          in   1           single clock; all state updates on rising edge
//  reset        in   1           asynchronous, active-low reset
//  in_valid     in   1           result valid from shared-resource stage
//  in_data      in   DATA_WIDTH  result data from shared-resource stage
//  in_flush     in   1           lane flush request
//  out_stall    out  1           to upstream: stage cannot accept this cycle
//  in_stall     in   1           from downstream: consumer not ready
//  out_valid    out  1           head entry valid to downstream
//  out_data     out  DATA_WIDTH  head entry data
//  out_flush    out  1           registered flush pulse to downstream
//  accept_count out  CNT_WIDTH   results delivered downstream (saturating)
//  stall_count  out  CNT_WIDTH   cycles with out_valid=1 and in_stall=1 (saturating)
// BEHAVIOUR
//  - Reset (reset=0, async): FIFO emptied, read/write pointers and occupancy = 0.
//    out_valid=0, out_stall=0, out_flush=0, out_data=0, both counters = 0.
//  - Enqueue: enq = in_valid & !out_stall & !in_flush. Write in_data at wr_ptr; wr_ptr wraps
//    modulo DEPTH.
//  - Dequeue: deq = out_valid & !in_stall & !in_flush. rd_ptr wraps modulo DEPTH.
//  - out_stall = (occupancy == DEPTH). Decoded from registers only; no combinational path
//    from in_stall. When full, no enqueue occurs even if a dequeue happens in the same cycle.
//  - out_valid = (occupancy != 0). out_data = entry at rd_ptr, forced to 0 when empty.
//  - Latency: a result accepted at edge N is visible on out_valid/out_data after edge N.
//    No same-cycle bypass.
//  - Throughput: 1 result/cycle when not full and not stalled. Simultaneous enq+deq keeps
//    occupancy unchanged.
//  - Occupancy FSM, kept in a state register:
//    - EMPTY->PARTIAL on enq.
//    - PARTIAL->FULL on enq&!deq when occupancy==DEPTH-1.
//    - PARTIAL->EMPTY on deq&!enq when occupancy==1.
//    - FULL->PARTIAL on deq.
//    - Any state->EMPTY on in_flush.
//  - Flush (synchronous): on an edge with in_flush=1, FIFO cleared and pointers zeroed.
//    Any in_valid and any dequeue in that cycle are discarded and not counted.
//    out_flush=1 for exactly the following cycle per flush cycle (out_flush <= in_flush).
//  - Counters: accept_count += 1 on deq. stall_count += 1 each cycle out_valid & in_stall
//    & !in_flush. Both saturate at 2^CNT_WIDTH-1 (no wrap). Cleared only by reset, not by
//    flush.
//  - Data ordering is strictly FIFO. No result is duplicated or dropped except by flush.
//  - Reset asserted mid-operation: all state clears immediately (asynchronously).
//    Operation resumes on the first edge after reset=1.
// TESTING
//  1 Stream: in_stall=0; in_valid=1 with data 1..8 on consecutive cycles
//    -> out_data 1..8 each one cycle later; out_stall never 1; accept_count=8.
//  2 Fill: in_stall=1; send 0xA,0xB,0xC -> occupancy 2, out_stall=1 after 2nd edge,
//    0xC not accepted. Then in_stall=0 -> 0xA then 0xB out; out_stall drops after 1st deq.
//  3 Stall count: 1 entry held with in_stall=1 for 5 cycles -> stall_count=5;
//    accept_count unchanged until release.
//  4 Flush: FIFO full; in_flush=1 one cycle with in_valid=1
//    -> next cycle out_valid=0, out_stall=0, out_flush=1 for one cycle;
//    counters unchanged; next sent 0x55 appears first.
//  5 Wrap: DEPTH=2; 10 alternating enq/deq patterns -> order preserved across pointer wrap.
//  6 Reset/saturation: CNT_WIDTH=4; 20 deliveries -> accept_count=15 (holds).
//    Pulse reset=0 mid-stream -> all outputs 0 asynchronously.

Source files
------------

// File: rtl/result_skid_stage.sv
// Per-lane output stage: registers results into a small in-order skid FIFO and forwards
// valid/stall/flush, with saturating delivery and stall counters.
module result_skid_stage #(
  parameter int DATA_WIDTH = 32,
  parameter int DEPTH      = 2,
  parameter int CNT_WIDTH  = 16
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  in_valid,
  input  logic [DATA_WIDTH-1:0] in_data,
  input  logic                  in_flush,
  output logic                  out_stall,
  input  logic                  in_stall,
  output logic                  out_valid,
  output logic [DATA_WIDTH-1:0] out_data,
  output logic                  out_flush,
  output logic [CNT_WIDTH-1:0]  accept_count,
  output logic [CNT_WIDTH-1:0]  stall_count
);
  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int OW = $clog2(DEPTH + 1);

  typedef enum logic [1:0] {EMPTY, PARTIAL, FULL} state_t;

  state_t                state;
  logic [OW-1:0]         occ;
  logic [PW-1:0]         wr_ptr;
  logic [PW-1:0]         rd_ptr;
  logic [DATA_WIDTH-1:0] mem [DEPTH];
  logic                  enq;
  logic                  deq;

  // Status decoded purely from the state register, so in_stall never reaches out_stall.
  assign out_stall = (state == FULL);
  assign out_valid = (state != EMPTY);
  assign out_data  = out_valid ? mem[rd_ptr] : '0;

  assign enq = in_valid & ~out_stall & ~in_flush;
  assign deq = out_valid & ~in_stall & ~in_flush;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state  <= EMPTY;
      occ    <= '0;
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else if (in_flush) begin
      state  <= EMPTY;
      occ    <= '0;
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      occ <= occ + OW'(enq) - OW'(deq);
      if (enq) wr_ptr <= PW'(wr_ptr + 1'b1);
      if (deq) rd_ptr <= PW'(rd_ptr + 1'b1);
      case (state)
        EMPTY:   if (enq) state <= PARTIAL;
        PARTIAL: begin
          if (enq && !deq && occ == OW'(DEPTH - 1))
            state <= FULL;
          else if (deq && !enq && occ == OW'(1))
            state <= EMPTY;
        end
        FULL:    if (deq) state <= PARTIAL;
        default: state <= EMPTY;
      endcase
    end
  end

  // Storage needs no reset: out_data is masked whenever the FIFO is empty.
  always_ff @(posedge clk) begin
    if (enq) mem[wr_ptr] <= in_data;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      out_flush    <= 1'b0;
      accept_count <= '0;
      stall_count  <= '0;
    end else begin
      out_flush <= in_flush;
      if (deq && accept_count != '1)
        accept_count <= accept_count + 1'b1;
      if (out_valid && in_stall && !in_flush && stall_count != '1)
        stall_count <= stall_count + 1'b1;
    end
  end
endmodule

// File: tb/tb_result_skid_stage.sv
// Directed bench for result_skid_stage with a queue scoreboard and a cycle-level reference model.
module tb_result_skid_stage;
  localparam int DW    = 32;
  localparam int DEPTH = 2;
  localparam int CW    = 4;
  localparam int CMAX  = 15;

  logic          clk = 1'b0;
  logic          reset = 1'b0;
  logic          in_valid = 1'b0;
  logic [DW-1:0] in_data = '0;
  logic          in_flush = 1'b0;
  logic          in_stall = 1'b0;
  logic          out_stall;
  logic          out_valid;
  logic [DW-1:0] out_data;
  logic          out_flush;
  logic [CW-1:0] accept_count;
  logic [CW-1:0] stall_count;

  int checks = 0;
  int failures = 0;

  logic [DW-1:0] sb[$];
  int  acc_m = 0;
  int  stl_m = 0;
  logic flush_m = 1'b0;

  result_skid_stage #(.DATA_WIDTH(DW), .DEPTH(DEPTH), .CNT_WIDTH(CW)) dut (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_data(in_data),
    .in_flush(in_flush), .out_stall(out_stall), .in_stall(in_stall),
    .out_valid(out_valid), .out_data(out_data), .out_flush(out_flush),
    .accept_count(accept_count), .stall_count(stall_count)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Compare all outputs against the model, then advance the model and the DUT by one edge.
  task automatic cycle(input logic v, input logic [DW-1:0] d, input logic s, input logic f);
    logic e_m, q_m;
    in_valid = v; in_data = d; in_stall = s; in_flush = f;
    #1;
    chk("out_valid", {31'b0, out_valid}, {31'b0, (sb.size() != 0)});
    chk("out_stall", {31'b0, out_stall}, {31'b0, (sb.size() == DEPTH)});
    chk("out_data", out_data, (sb.size() != 0) ? sb[0] : 32'h0);
    chk("out_flush", {31'b0, out_flush}, {31'b0, flush_m});
    chk("accept_count", {28'b0, accept_count}, 32'(acc_m));
    chk("stall_count", {28'b0, stall_count}, 32'(stl_m));
    e_m = v && (sb.size() < DEPTH) && !f;
    q_m = (sb.size() != 0) && !s && !f;
    if ((sb.size() != 0) && s && !f && stl_m < CMAX) stl_m++;
    if (q_m && acc_m < CMAX) acc_m++;
    if (f) sb.delete();
    else begin
      if (q_m) void'(sb.pop_front());
      if (e_m) sb.push_back(d);
    end
    flush_m = f;
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic do_reset();
    reset = 1'b0;
    in_valid = 1'b0; in_flush = 1'b0; in_stall = 1'b0; in_data = '0;
    repeat (2) @(negedge clk);
    chk("rst_out_valid", {31'b0, out_valid}, 32'h0);
    chk("rst_out_stall", {31'b0, out_stall}, 32'h0);
    chk("rst_out_flush", {31'b0, out_flush}, 32'h0);
    chk("rst_out_data", out_data, 32'h0);
    chk("rst_accept", {28'b0, accept_count}, 32'h0);
    chk("rst_stall_cnt", {28'b0, stall_count}, 32'h0);
    sb.delete(); acc_m = 0; stl_m = 0; flush_m = 1'b0;
    reset = 1'b1;
  endtask

  initial begin
    do_reset();

    // Stream 1..8 with no backpressure, then drain.
    for (int i = 1; i <= 8; i++) cycle(1'b1, 32'(i), 1'b0, 1'b0);
    cycle(1'b0, 32'h0, 1'b0, 1'b0);
    cycle(1'b0, 32'h0, 1'b0, 1'b0);
    chk("stream_accept8", {28'b0, accept_count}, 32'd8);

    // Fill under stall; 0xC must be refused.
    do_reset();
    cycle(1'b1, 32'hA, 1'b1, 1'b0);
    cycle(1'b1, 32'hB, 1'b1, 1'b0);
    chk("fill_full", {31'b0, out_stall}, 32'h1);
    cycle(1'b1, 32'hC, 1'b1, 1'b0);
    chk("fill_head_A", out_data, 32'hA);
    cycle(1'b0, 32'h0, 1'b0, 1'b0);
    chk("fill_stall_drop", {31'b0, out_stall}, 32'h0);
    chk("fill_head_B", out_data, 32'hB);
    cycle(1'b0, 32'h0, 1'b0, 1'b0);
    cycle(1'b0, 32'h0, 1'b0, 1'b0);

    // One entry held for 5 stalled cycles.
    do_reset();
    cycle(1'b1, 32'h33, 1'b1, 1'b0);
    for (int i = 0; i < 5; i++) cycle(1'b0, 32'h0, 1'b1, 1'b0);
    chk("stall_cnt5", {28'b0, stall_count}, 32'd5);
    chk("stall_acc0", {28'b0, accept_count}, 32'd0);
    cycle(1'b0, 32'h0, 1'b0, 1'b0);
    chk("stall_acc1", {28'b0, accept_count}, 32'd1);

    // Flush a full FIFO with a concurrent in_valid.
    do_reset();
    cycle(1'b1, 32'h11, 1'b1, 1'b0);
    cycle(1'b1, 32'h22, 1'b1, 1'b0);
    cycle(1'b1, 32'h77, 1'b0, 1'b1);
    chk("flush_empty", {31'b0, out_valid}, 32'h0);
    chk("flush_pulse", {31'b0, out_flush}, 32'h1);
    chk("flush_acc", {28'b0, accept_count}, 32'd0);
    cycle(1'b1, 32'h55, 1'b1, 1'b0);
    chk("flush_first55", out_data, 32'h55);
    chk("flush_pulse_end", {31'b0, out_flush}, 32'h0);
    cycle(1'b0, 32'h0, 1'b0, 1'b0);
    cycle(1'b0, 32'h0, 1'b0, 1'b0);

    // Mixed enq/deq patterns across pointer wrap.
    do_reset();
    for (int i = 0; i < 10; i++)
      cycle(1'b1, 32'h100 + 32'(i), (i % 3) == 0, 1'b0);
    for (int i = 0; i < 10; i++)
      cycle((i % 2) == 0, 32'h200 + 32'(i), (i % 4) == 1, 1'b0);
    for (int i = 0; i < 3; i++) cycle(1'b0, 32'h0, 1'b0, 1'b0);

    // Saturation at 15 deliveries.
    do_reset();
    for (int i = 0; i < 20; i++) cycle(1'b1, 32'h300 + 32'(i), 1'b0, 1'b0);
    cycle(1'b0, 32'h0, 1'b0, 1'b0);
    cycle(1'b0, 32'h0, 1'b0, 1'b0);
    chk("sat_accept15", {28'b0, accept_count}, 32'd15);

    // Asynchronous reset mid-stream, away from any clock edge.
    cycle(1'b1, 32'h400, 1'b1, 1'b0);
    cycle(1'b1, 32'h401, 1'b1, 1'b0);
    #2 reset = 1'b0;
    #1;
    chk("areset_valid", {31'b0, out_valid}, 32'h0);
    chk("areset_stall", {31'b0, out_stall}, 32'h0);
    chk("areset_data", out_data, 32'h0);
    chk("areset_acc", {28'b0, accept_count}, 32'h0);
    chk("areset_stl", {28'b0, stall_count}, 32'h0);
    @(negedge clk);
    do_reset();
    cycle(1'b1, 32'h500, 1'b0, 1'b0);
    cycle(1'b0, 32'h0, 1'b0, 1'b0);
    cycle(1'b0, 32'h0, 1'b0, 1'b0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
